// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture slice: FSM state encoding,
// default counter width and the saturation limit helper.
package pwm_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        HIGH = 2'b10,
        LOW  = 2'b11
    } pwm_state_t;

    // Largest value a w-bit saturating counter may hold (w <= 31).
    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// edge detector. Outputs the synchronised level s plus one-cycle rise/fall.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    // rise/fall are registered alongside s_d, so they stay aligned with s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            s_d    <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~s_d;
            fall   <= ~sync_q[SYNC_STAGES-1] & s_d;
        end
    end

    assign s = s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period measurement with valid/ready result interface.
// Optional stuck-input timeout result: define PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overflow,
    output logic             missed,
    output logic             meas_valid,
    input  logic             meas_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic pwm_level, rise, fall;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pwm_in),
        .s        (pwm_level),
        .rise     (rise),
        .fall     (fall)
    );

    pwm_state_t       state, state_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt, pcnt, pcnt_nxt;
    logic             sat, sat_nxt;
    logic             load, load_ovf;
    logic [CNT_W-1:0] load_h, load_p;
    logic             h_at_max, p_at_max;
    logic [CNT_W-1:0] h_inc, p_inc;

    always_comb begin
        h_at_max  = (hcnt == CNT_MAX);
        p_at_max  = (pcnt == CNT_MAX);
        h_inc     = h_at_max ? hcnt : hcnt + CNT_ONE;
        p_inc     = p_at_max ? pcnt : pcnt + CNT_ONE;
        state_nxt = state;
        hcnt_nxt  = hcnt;
        pcnt_nxt  = pcnt;
        sat_nxt   = sat;
        load      = 1'b0;
        load_h    = hcnt;
        load_p    = pcnt;
        load_ovf  = sat;

        case (state)
            IDLE: begin
                hcnt_nxt = '0;
                pcnt_nxt = '0;
                sat_nxt  = 1'b0;
                if (en) state_nxt = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_nxt = HIGH;
                    hcnt_nxt  = CNT_ONE;
                    pcnt_nxt  = CNT_ONE;
                    sat_nxt   = 1'b0;
                end
            end
            HIGH: begin
                // The fall cycle is the first low cycle: only the period counts it.
                if (fall) begin
                    state_nxt = LOW;
                    pcnt_nxt  = p_inc;
                    sat_nxt   = sat | p_at_max;
                end else begin
                    hcnt_nxt = pwm_level ? h_inc : hcnt;
                    pcnt_nxt = p_inc;
                    sat_nxt  = sat | (pwm_level & h_at_max) | p_at_max;
                end
            end
            LOW: begin
                if (rise) begin
                    load      = 1'b1;
                    state_nxt = HIGH;
                    hcnt_nxt  = CNT_ONE;
                    pcnt_nxt  = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else begin
                    pcnt_nxt = p_inc;
                    sat_nxt  = sat | p_at_max;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef PWM_CAPTURE_TIMEOUT_EN
        // pcnt >= hcnt always, so pcnt reaching its limit marks a stuck input.
        if (((state == HIGH) || ((state == LOW) && !rise)) && p_at_max) begin
            load      = 1'b1;
            load_h    = hcnt;
            load_p    = CNT_MAX;
            load_ovf  = 1'b1;
            state_nxt = ARM;
            hcnt_nxt  = '0;
            pcnt_nxt  = '0;
            sat_nxt   = 1'b0;
        end
`else
        load_p = load_p;
`endif

        if (!en) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
            pcnt_nxt  = '0;
            sat_nxt   = 1'b0;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hcnt  <= '0;
            pcnt  <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            pcnt  <= pcnt_nxt;
            sat   <= sat_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            overflow   <= 1'b0;
            missed     <= 1'b0;
            meas_valid <= 1'b0;
        end else if (load) begin
            high_cnt   <= load_h;
            period_cnt <= load_p;
            overflow   <= load_ovf;
            missed     <= meas_valid & ~meas_ready;
            meas_valid <= 1'b1;
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
            missed     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: scoreboarded results for an 8-bit and a
// 4-bit instance, plus handshake, saturation, enable and reset scenarios.
module tb_pwm_capture;

    typedef struct {
        int h;
        int p;
        int o;
        int m;
    } exp_t;

    logic clk = 1'b0;
    logic reset, en, ready, pwm8, pwm4;

    logic [7:0] high8, period8;
    logic       ovf8, missed8, valid8;
    logic [3:0] high4, period4;
    logic       ovf4, missed4, valid4;

    int checks   = 0;
    int failures = 0;
    int rcount8  = 0;
    int rcount4  = 0;
    int snap;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .en(en), .pwm_in(pwm8),
        .high_cnt(high8), .period_cnt(period8), .overflow(ovf8),
        .missed(missed8), .meas_valid(valid8), .meas_ready(ready)
    );

    pwm_capture #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .reset(reset), .en(en), .pwm_in(pwm4),
        .high_cnt(high4), .period_cnt(period4), .overflow(ovf4),
        .missed(missed4), .meas_valid(valid4), .meas_ready(ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int h, input int p, input int o, input int m);
        exp_t e;
        e.h = h; e.p = p; e.o = o; e.m = m;
        q8.push_back(e);
    endtask

    task automatic push4(input int h, input int p, input int o, input int m);
        exp_t e;
        e.h = h; e.p = p; e.o = o; e.m = m;
        q4.push_back(e);
    endtask

    // Drives one period on pwm8 and records its expected measurement.
    task automatic period8_drive(input int h, input int l, input bit record);
        pwm8 = 1'b1;
        repeat (h) tick();
        pwm8 = 1'b0;
        repeat (l) tick();
        if (record) push8(h, h + l, 0, 0);
    endtask

    task automatic period4_drive(input int h, input int l);
        pwm4 = 1'b1;
        repeat (h) tick();
        pwm4 = 1'b0;
        repeat (l) tick();
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (q8.size() != 0 || q4.size() != 0); i++) tick();
        check("drain_pending", q8.size() + q4.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset && valid8 && ready) begin
            rcount8++;
            if (q8.size() == 0) begin
                check("unexpected_result8", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("high8", high8, e.h);
                check("period8", period8, e.p);
                check("ovf8", ovf8, e.o);
                check("missed8", missed8, e.m);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && valid4 && ready) begin
            rcount4++;
            if (q4.size() == 0) begin
                check("unexpected_result4", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("high4", high4, e.h);
                check("period4", period4, e.p);
                check("ovf4", ovf4, e.o);
                check("missed4", missed4, e.m);
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; ready = 1'b1; pwm8 = 1'b0; pwm4 = 1'b0;
        repeat (3) tick();
        check("rst_valid", valid8, 0);
        check("rst_high", high8, 0);
        check("rst_period", period8, 0);
        check("rst_ovf", ovf8, 0);
        check("rst_missed", missed8, 0);
        reset = 1'b1;
        tick();

        // Steady 4/6 waveform: first rise discarded, one result per period.
        en = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) period8_drive(4, 6, 1'b1);
        pwm8 = 1'b1;
        repeat (4) tick();
        pwm8 = 1'b0;
        drain(30);
        check("steady_count", rcount8, 4);
        en = 1'b0;
        repeat (3) tick();

        // Varied periods including a single-cycle pulse; latency on final rise.
        en = 1'b1;
        repeat (4) tick();
        period8_drive(1, 5, 1'b1);
        period8_drive(7, 2, 1'b1);
        period8_drive(3, 3, 1'b1);
        pwm8 = 1'b1;
        repeat (3) tick();
        check("latency_early", valid8, 0);
        tick();
        check("latency_edge", valid8, 1);
        tick();
        pwm8 = 1'b0;
        drain(30);
        en = 1'b0;
        repeat (3) tick();

        // Consumer stalled for three results; en drop keeps the pending one.
        ready = 1'b0;
        en = 1'b1;
        repeat (4) tick();
        period8_drive(4, 6, 1'b0);
        period8_drive(2, 5, 1'b0);
        period8_drive(6, 3, 1'b0);
        pwm8 = 1'b1;
        repeat (2) tick();
        pwm8 = 1'b0;
        repeat (8) tick();
        en = 1'b0;
        repeat (3) tick();
        check("held_valid", valid8, 1);
        check("held_high", high8, 6);
        check("held_period", period8, 9);
        check("held_missed", missed8, 1);
        check("held_ovf", ovf8, 0);
        push8(6, 9, 0, 1);
        ready = 1'b1;
        drain(10);
        tick();
        check("accepted_valid", valid8, 0);
        check("accepted_missed", missed8, 0);

        // 4-bit instance saturates, then a normal period clears overflow.
        en = 1'b1;
        repeat (4) tick();
        push4(15, 15, 1, 0);
        period4_drive(20, 5);
        push4(3, 7, 0, 0);
        period4_drive(3, 4);
        pwm4 = 1'b1;
        repeat (2) tick();
        pwm4 = 1'b0;
        drain(30);
        check("cnt4_count", rcount4, 2);
        en = 1'b0;
        repeat (3) tick();

        // Input stuck high well past the 8-bit counter range.
        en = 1'b1;
        repeat (4) tick();
        snap = rcount8;
`ifdef PWM_CAPTURE_TIMEOUT_EN
        push8(255, 255, 1, 0);
`endif
        pwm8 = 1'b1;
        repeat (300) tick();
        pwm8 = 1'b0;
        repeat (5) tick();
        en = 1'b0;
        drain(10);
`ifdef PWM_CAPTURE_TIMEOUT_EN
        check("stuck_results", rcount8 - snap, 1);
`else
        check("stuck_results", rcount8 - snap, 0);
`endif
        repeat (3) tick();

        // Reset mid-period with a pending result, then re-arm from scratch.
        ready = 1'b0;
        en = 1'b1;
        repeat (4) tick();
        period8_drive(3, 3, 1'b0);
        period8_drive(3, 3, 1'b0);
        pwm8 = 1'b1;
        repeat (4) tick();
        check("pre_reset_valid", valid8, 1);
        reset = 1'b0;
        #2;
        check("mid_rst_valid", valid8, 0);
        check("mid_rst_high", high8, 0);
        check("mid_rst_period", period8, 0);
        check("mid_rst_missed", missed8, 0);
        check("mid_rst_ovf", ovf8, 0);
        pwm8 = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        ready = 1'b1;
        snap = rcount8;
        repeat (4) tick();
        period8_drive(5, 5, 1'b1);
        pwm8 = 1'b1;
        repeat (2) tick();
        pwm8 = 1'b0;
        drain(30);
        repeat (4) tick();
        check("rearm_count", rcount8 - snap, 1);
        check("final_queue", q8.size() + q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
